// File: rtl/tra_mes_arbiter.sv
// Round-robin arbiter that shares the transmit message buffer and sequences the CAN transmitter.
// Optional WAIT watchdog is built only when TRA_TIMEOUT_EN is defined.
module tra_mes_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MSG_W       = 76,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MSG_W-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  output logic                   buf_en,
  output logic [MSG_W-1:0]       buf_data,
  output logic [4:0]             act_bus,
  output logic                   tx_start,
  input  logic                   tx_done,
  input  logic                   tx_err,
  output logic                   busy,
  output logic                   drop,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               buf_en_q, buf_en_d;
  logic [MSG_W-1:0]   buf_data_q, buf_data_d;
  logic [4:0]         act_bus_q, act_bus_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               tmo_hit;

  logic [MSG_W-1:0]   msg_arr [N_REQ];
  logic [PTR_W-1:0]   sel_c;
  logic               found_c;
  logic [PTR_W-1:0]   ptr_inc;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign msg_arr[gi] = data_in[gi*MSG_W +: MSG_W];
    end
  endgenerate

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    sel_c   = '0;
    found_c = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_c && req[(int'(ptr_q) + k) % N_REQ]) begin
        found_c = 1'b1;
        sel_c   = PTR_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign ptr_inc = (sel_q == PTR_W'(N_REQ - 1)) ? '0 : sel_q + PTR_W'(1);

`ifdef TRA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q;

  // Counter is zero in the first WAIT cycle because every entry passes through START.
  always_comb begin
    to_cnt_d = (state_q == ST_WAIT) ? to_cnt_q + TO_W'(1) : '0;
    tmo_hit  = (state_q == ST_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) && !tx_done && !tx_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= tmo_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    retry_d    = retry_q;
    grant_d    = '0;
    buf_en_d   = 1'b0;
    buf_data_d = buf_data_q;
    act_bus_d  = act_bus_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d    = LOAD;
          sel_d      = sel_c;
          grant_d    = N_REQ'(1) << sel_c;
          buf_en_d   = 1'b1;
          buf_data_d = msg_arr[sel_c];
          act_bus_d  = msg_arr[sel_c][20:16];
          retry_d    = '0;
        end
      end
      LOAD: begin
        state_d    = START;
        tx_start_d = 1'b1;
      end
      START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
          ptr_d   = ptr_inc;
        end else if (tx_err || tmo_hit) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d    = retry_q + RTY_W'(1);
            state_d    = START;
            tx_start_d = 1'b1;
          end else begin
            drop_d  = 1'b1;
            ptr_d   = ptr_inc;
            state_d = IDLE;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      retry_q    <= '0;
      grant_q    <= '0;
      buf_en_q   <= 1'b0;
      buf_data_q <= '0;
      act_bus_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      retry_q    <= retry_d;
      grant_q    <= grant_d;
      buf_en_q   <= buf_en_d;
      buf_data_q <= buf_data_d;
      act_bus_q  <= act_bus_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign buf_en   = buf_en_q;
  assign buf_data = buf_data_q;
  assign act_bus  = act_bus_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign drop     = drop_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_tra_mes_arbiter.sv
// Randomized self-checking bench for tra_mes_arbiter against a transaction-level model.
module tb_tra_mes_arbiter;
  localparam int N  = 4;
  localparam int W  = 76;
  localparam int MR = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic           buf_en;
  logic [W-1:0]   buf_data;
  logic [4:0]     act_bus;
  logic           tx_start;
  logic           tx_done;
  logic           tx_err;
  logic           busy;
  logic           drop;
  logic [7:0]     err_cnt;
  logic           timeout;

  int n_vec = 0;
  int n_bad = 0;
  int ptr_m = 0;
  int cnt_m = 0;

  tra_mes_arbiter #(.N_REQ(N), .MSG_W(W), .MAX_RETRY(MR), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .grant(grant), .buf_en(buf_en),
    .buf_data(buf_data), .act_bus(act_bus), .tx_start(tx_start), .tx_done(tx_done),
    .tx_err(tx_err), .busy(busy), .drop(drop), .err_cnt(err_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_msg(input int i);
    logic [95:0] tmp;
    tmp = {$urandom, $urandom, $urandom};
    data_in[i*W +: W] = tmp[W-1:0];
  endtask

  // One complete message: grant, n_err failures, then success or drop.
  task automatic do_txn(input int n_err, input bit both, input bit noise, input bit keep_req,
                        input int dmin, input int dmax);
    int sel, starts, exp_starts, attempt;
    logic [W-1:0] exp_d;
    sel   = pick(req, ptr_m);
    exp_d = data_in[sel*W +: W];
    exp_starts = (n_err > MR) ? MR + 1 : n_err + 1;
    tick();
    n_vec++; if (grant !== N'(1 << sel)) begin n_bad++; $display("FAIL grant got=%b exp=%b", grant, N'(1 << sel)); end
    n_vec++; if (buf_en !== 1'b1) begin n_bad++; $display("FAIL buf_en got=%b exp=1", buf_en); end
    n_vec++; if (buf_data !== exp_d) begin n_bad++; $display("FAIL buf_data got=%h exp=%h", buf_data, exp_d); end
    n_vec++; if (act_bus !== exp_d[20:16]) begin n_bad++; $display("FAIL act_bus got=%h exp=%h", act_bus, exp_d[20:16]); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_load got=%b exp=1", busy); end
    if (!keep_req) req[sel] = 1'b0;
    if (noise) begin tx_done = 1'($urandom_range(0, 1)); tx_err = 1'($urandom_range(0, 1)); end
    tick();
    n_vec++; if (tx_start !== 1'b1 || grant !== '0) begin n_bad++; $display("FAIL start got=%b grant=%b exp=1/0000", tx_start, grant); end
    starts = 1;
    attempt = 0;
    forever begin
      if (noise) begin tx_done = 1'($urandom_range(0, 1)); tx_err = 1'($urandom_range(0, 1)); end
      tick();
      tx_done = 1'b0; tx_err = 1'b0;
      n_vec++; if (tx_start !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL wait_entry tx_start=%b busy=%b exp=0/1", tx_start, busy); end
      repeat ($urandom_range(dmin, dmax)) tick();
      if (attempt < n_err) begin tx_err = 1'b1; end
      else begin tx_done = 1'b1; tx_err = both; end
      tick();
      tx_done = 1'b0; tx_err = 1'b0;
      if (attempt >= n_err) begin
        n_vec++; if (busy !== 1'b0 || drop !== 1'b0) begin n_bad++; $display("FAIL done busy=%b drop=%b exp=0/0", busy, drop); end
        ptr_m = (sel + 1) % N;
        break;
      end else if (attempt < MR) begin
        n_vec++; if (tx_start !== 1'b1 || drop !== 1'b0) begin n_bad++; $display("FAIL retry tx_start=%b drop=%b exp=1/0", tx_start, drop); end
        if (tx_start === 1'b1) starts++;
        attempt++;
      end else begin
        n_vec++; if (drop !== 1'b1 || tx_start !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL drop drop=%b tx_start=%b busy=%b exp=1/0/0", drop, tx_start, busy); end
        if (cnt_m < 255) cnt_m++;
        ptr_m = (sel + 1) % N;
        break;
      end
    end
    n_vec++; if (starts !== exp_starts) begin n_bad++; $display("FAIL start_count got=%0d exp=%0d", starts, exp_starts); end
    n_vec++; if (err_cnt !== 8'(cnt_m)) begin n_bad++; $display("FAIL err_cnt got=%0d exp=%0d", err_cnt, cnt_m); end
    $display("txn sel=%0d n_err=%0d both=%0d starts=%0d err_cnt=%0d", sel, n_err, both, starts, err_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; data_in = '0; tx_done = 1'b0; tx_err = 1'b0;
    tick(); tick();
    n_vec++; if ({grant, buf_en, buf_data, act_bus, tx_start, busy, drop, err_cnt, timeout} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got busy=%b grant=%b buf_data=%h err_cnt=%0d exp=all zero", busy, grant, buf_data, err_cnt); end
    @(negedge clk); rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0 || grant !== '0) begin n_bad++; $display("FAIL idle_after_reset busy=%b grant=%b exp=0/0000", busy, grant); end
    ptr_m = 0; cnt_m = 0;
  endtask

  task automatic test_basic();
    data_in[1*W +: W] = 76'hA_BCDE_0000_0015_1234;
    req = 4'b0010;
    tick();
    n_vec++; if (grant !== 4'b0010 || buf_data !== 76'hA_BCDE_0000_0015_1234 || act_bus !== 5'h15) begin
      n_bad++; $display("FAIL basic grant=%b buf_data=%h act_bus=%h exp=0010/abcde0000_00151234/15", grant, buf_data, act_bus); end
    req = '0;
    tick();
    n_vec++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL basic_start got=%b exp=1", tx_start); end
    tick(); tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_done busy=%b exp=0", busy); end
    ptr_m = 2;
    $display("txn basic sel=1 act_bus=%h", act_bus);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) set_msg(i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) do_txn(0, 1'b0, 1'b0, 1'b1, 1, 1);
    req = '0;
  endtask

  task automatic test_retry();
    set_msg(0); req = 4'b0001;
    do_txn(3, 1'b0, 1'b0, 1'b0, 0, 2);
    set_msg(3); req = 4'b1000;
    do_txn(4, 1'b0, 1'b0, 1'b0, 0, 2);
  endtask

  task automatic test_done_err_same();
    set_msg(2); req = 4'b0100;
    do_txn(0, 1'b1, 1'b0, 1'b0, 0, 1);
  endtask

  task automatic test_wait_response();
    set_msg(1); req = 4'b0010;
    tick(); req = '0;
    tick(); tick();
`ifdef TRA_TIMEOUT_EN
    for (int a = 0; a <= MR; a++) begin
      for (int c = 1; c < TO; c++) begin
        n_vec++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL early_timeout cycle=%0d got=1 exp=0", c); end
        tick();
      end
      tick();
      n_vec++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout attempt=%0d got=%b exp=1", a, timeout); end
      if (a < MR) begin
        n_vec++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL timeout_retry got=%b exp=1", tx_start); end
        tick();
      end else begin
        if (cnt_m < 255) cnt_m++;
        n_vec++; if (drop !== 1'b1 || err_cnt !== 8'(cnt_m)) begin n_bad++; $display("FAIL timeout_drop drop=%b err_cnt=%0d exp=1/%0d", drop, err_cnt, cnt_m); end
      end
    end
`else
    for (int c = 0; c < 40; c++) begin
      n_vec++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL hang busy=%b timeout=%b exp=1/0", busy, timeout); end
      tick();
    end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hang_done busy=%b exp=0", busy); end
`endif
    ptr_m = 2;
    $display("txn wait_response err_cnt=%0d", err_cnt);
  endtask

  task automatic test_async_reset();
    set_msg(1); req = 4'b0010;
    do_txn(0, 1'b0, 1'b0, 1'b0, 0, 0);
    set_msg(2); req = 4'b0100;
    tick(); req = '0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({grant, buf_en, buf_data, act_bus, tx_start, busy, drop, err_cnt, timeout} !== '0) begin
      n_bad++; $display("FAIL async_reset busy=%b buf_data=%h act_bus=%h err_cnt=%0d exp=all zero", busy, buf_data, act_bus, err_cnt); end
    @(negedge clk); rst = 1'b0;
    ptr_m = 0; cnt_m = 0;
    set_msg(0); set_msg(3); req = 4'b1001;
    do_txn(0, 1'b0, 1'b0, 1'b0, 0, 1);
    req = '0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    req = '0;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(0, 1) == 1) begin set_msg(i); req[i] = 1'b1; end
      if (req == '0) begin
        int j;
        j = $urandom_range(0, N - 1);
        set_msg(j); req[j] = 1'b1;
      end
      do_txn($urandom_range(0, MR + 1), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 0, 3);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_retry();
    test_done_err_same();
    test_wait_response();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
